banked_mem_resp: RTL and testbench

//  Multi-cycle, multi-bank main-memory responder. It answers the rd_mem/wr_mem

---
 rtl/banked_mem_resp.sv | 114 +++++++++++
 tb/tb_banked_mem_resp.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/banked_mem_resp.sv
// Multi-bank word memory answering cache rd/wr requests with fixed read latency.
// Optional macro BANKMEM_CONFLICT_EN enables per-bank busy counters and stall.
module banked_mem_resp #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WORD_AW   = 10,
  parameter int NUM_BANKS = 4,
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int CNT_W  = $clog2(BANK_BUSY + 1);

  // Handshake: a legal request (exactly one of rd/wr, even address) is consumed
  // at the rising edge unless stall is high; while stall is high the requester
  // holds the request. Illegal requests are dropped and flagged on err next cycle.
  logic               w_legal;
  logic               w_illegal;
  logic               w_accept;
  logic [WORD_AW-1:0] w_idx;
  logic               w_unused_addr;

  assign w_legal       = (rd ^ wr) & ~addr[0];
  assign w_illegal     = (rd & wr) | ((rd | wr) & addr[0]);
  assign w_idx         = addr[WORD_AW:1];
  assign w_unused_addr = ^addr[ADDR_W-1:WORD_AW+1];

`ifdef BANKMEM_CONFLICT_EN
  logic [BANK_W-1:0] w_bank;
  logic              w_blocked;
  logic [CNT_W-1:0]  r_cnt [NUM_BANKS];

  assign w_bank = addr[BANK_W:1];
  // A bank in its final busy cycle (count 1) frees at this edge, so it can be
  // re-accepted exactly BANK_BUSY edges after its previous acceptance.
  assign w_blocked = (r_cnt[w_bank] > CNT_W'(1));
  assign stall     = w_legal & w_blocked;
  assign w_accept  = w_legal & ~w_blocked;

  always_comb begin
    busy = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      busy[b] = (r_cnt[b] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_accept && (w_bank == BANK_W'(b))) begin
          r_cnt[b] <= CNT_W'(BANK_BUSY);
        end else if (r_cnt[b] != '0) begin
          r_cnt[b] <= r_cnt[b] - CNT_W'(1);
        end
      end
    end
  end
`else
  assign busy     = '0;
  assign stall    = 1'b0;
  assign w_accept = w_legal;
`endif

  logic [DATA_W-1:0] r_mem [2**WORD_AW];
  logic [DATA_W-1:0] r_dat [RD_LAT];
  logic [RD_LAT-1:0] r_vld;
  logic              r_err;

  // Array and data pipeline carry no reset; the valid bits alone qualify data.
  always_ff @(posedge clk) begin
    if (w_accept && wr) begin
      r_mem[w_idx] <= data_in;
    end
    r_dat[0] <= r_mem[w_idx];
    for (int i = 1; i < RD_LAT; i++) begin
      r_dat[i] <= r_dat[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_err <= 1'b0;
    end else begin
      r_vld[0] <= w_accept & rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_err <= w_illegal;
    end
  end

  assign data_valid = r_vld[RD_LAT-1];
  assign data_out   = r_vld[RD_LAT-1] ? r_dat[RD_LAT-1] : '0;
  assign err        = r_err;

endmodule

// File: tb/tb_banked_mem_resp.sv
// Randomized bench for banked_mem_resp against a timestamp-based reference model.
// Follows BANKMEM_CONFLICT_EN to decide whether bank conflicts are modelled.
module tb_banked_mem_resp;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int WORD_AW   = 10;
  localparam int NUM_BANKS = 4;
  localparam int BANK_BUSY = 4;
  localparam int RD_LAT    = 2;
`ifdef BANKMEM_CONFLICT_EN
  localparam bit CONFLICT = 1'b1;
`else
  localparam bit CONFLICT = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic                 wr;
  logic                 rd;
  logic [DATA_W-1:0]    data_out;
  logic                 data_valid;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  banked_mem_resp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_AW(WORD_AW),
    .NUM_BANKS(NUM_BANKS), .BANK_BUSY(BANK_BUSY), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .data_valid(data_valid), .stall(stall), .busy(busy),
    .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model state
  logic [DATA_W-1:0] exp_q[$];
  int                due_q[$];
  logic [DATA_W-1:0] mem_m [2**WORD_AW];
  int                last_acc [NUM_BANKS];
  int                cyc;
  logic              exp_err;
  bit                last_accepted;
  logic              obs_stall;
  int                n_checks;
  int                n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    for (int b = 0; b < NUM_BANKS; b++) last_acc[b] = -100000;
    exp_err = 1'b0;
  endtask

  // One clock: present inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    logic [NUM_BANKS-1:0] exp_busy;
    bit legal;
    bit blocked;
    int b;
    int idx;
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
    legal   = (r ^ w) && !a[0];
    b       = (a >> 1) % NUM_BANKS;
    idx     = (a >> 1) % (2**WORD_AW);
    blocked = CONFLICT && legal && ((cyc + 1 - last_acc[b]) < BANK_BUSY);
    for (int bb = 0; bb < NUM_BANKS; bb++)
      exp_busy[bb] = CONFLICT && ((cyc - last_acc[bb]) < BANK_BUSY);
    obs_stall = stall;
    check("stall", stall, blocked);
    check("busy", busy, exp_busy);
    check("err", err, exp_err);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("data_valid", data_valid, 1);
      check("data_out", data_out, exp_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      check("data_valid_idle", data_valid, 0);
      check("data_out_idle", data_out, 0);
    end
    @(posedge clk);
    cyc++;
    exp_err       = (r & w) | ((r | w) & a[0]);
    last_accepted = legal && !blocked;
    if (last_accepted) begin
      last_acc[b] = cyc;
      if (w) mem_m[idx] = d;
      else begin
        exp_q.push_back(mem_m[idx]);
        due_q.push_back(cyc + RD_LAT - 1);
      end
    end
    #1;
  endtask

  // Re-present a request until accepted; counts stall cycles seen on the DUT.
  task automatic req(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, output int n_stall);
    int tries;
    tries   = 0;
    n_stall = 0;
    do begin
      step(r, w, a, d);
      n_stall += int'(obs_stall);
      tries++;
    end while (!last_accepted && tries < 20);
    check("req_accepted", last_accepted, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    rst = 1'b0;
    #1;
    model_clear();
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_err", err, 0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int ns;
    int kind;
    logic [ADDR_W-1:0] a;
    n_checks = 0; n_pass = 0; cyc = 0;
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; rst = 1'b0;
    model_clear();

    // reset hold and release
    do_reset(3);
    idle(2);

    // prefill a small window so every later read has known contents
    for (int i = 0; i < 64; i++) req(1'b0, 1'b1, ADDR_W'(i * 2), DATA_W'($urandom), ns);
    idle(4);

    // write then read back
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF, ns);
    check("wr_stall", ns, 0);
    idle(4);
    req(1'b1, 1'b0, 16'h0010, '0, ns);
    check("rd_stall", ns, 0);
    idle(4);

    // line burst across all banks
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, ADDR_W'(16'h0020 + i * 2), '0);
      check("burst_no_stall", obs_stall, 0);
    end
    idle(6);

    // same-bank conflict
    step(1'b1, 1'b0, 16'h0020, '0);
    req(1'b1, 1'b0, 16'h0028, '0, ns);
    check("conflict_stalls", ns, CONFLICT ? 3 : 0);
    idle(6);

    // illegal requests
    step(1'b1, 1'b1, 16'h0030, 16'h1234);
    step(1'b1, 1'b0, 16'h0031, '0);
    idle(4);

    // address aliasing above the word index
    req(1'b0, 1'b1, 16'h0810, 16'hCAFE, ns);
    idle(4);
    req(1'b1, 1'b0, 16'h0010, '0, ns);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      a    = ADDR_W'($urandom_range(0, 63) * 2) | ADDR_W'($urandom_range(0, 1) << 12);
      if (kind < 2)      step(1'b0, 1'b0, a, '0);
      else if (kind < 6) step(1'b1, 1'b0, a, '0);
      else if (kind < 9) step(1'b0, 1'b1, a, DATA_W'($urandom));
      else if ($urandom_range(0, 1) == 0) step(1'b1, 1'b1, a, DATA_W'($urandom));
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 0, a | 16'h0001, '0);
    end
    idle(6);

    // reset one cycle after a read accept drops the read, keeps the array
    req(1'b0, 1'b1, 16'h0012, 16'h5A5A, ns);
    idle(4);
    req(1'b1, 1'b0, 16'h0014, '0, ns);
    do_reset(2);
    idle(4);
    req(1'b1, 1'b0, 16'h0012, '0, ns);
    req(1'b1, 1'b0, 16'h0010, '0, ns);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
